// File: rtl/ultrasonic_pkg.sv
// ----------------------------------------------------------------------------
// ultrasonic_pkg
//   Shared types and helpers for the ultrasonic ranger block.
//   - state_t       : measurement FSM states
//   - MEAS_TIMEOUT  : value published on `measure` when a cycle times out
//   - ticks_per_us  : clock cycles per microsecond for a given clock frequency
// ----------------------------------------------------------------------------
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DONE_OK   = 3'd4,
        DONE_TO   = 3'd5,
        HOLD      = 3'd6
    } state_t;

    localparam logic [15:0] MEAS_TIMEOUT = 16'hFFFF;

    function automatic int unsigned ticks_per_us(input int unsigned clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_us_tick.sv
// ----------------------------------------------------------------------------
// us_tick
//   Microsecond prescaler. Counts 0..TICKS-1 and raises `tick` for the one
//   clock spent at the terminal count. `clr` forces the count back to 0 on
//   the next clock so a new FSM state always starts on a fresh microsecond.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clr   in  restart the count at 0 next clock
//   tick  out high during the terminal-count clock
// ----------------------------------------------------------------------------
module us_tick #(
    parameter int unsigned TICKS = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// ----------------------------------------------------------------------------
// ultrasonic_ranger
//   Drives an HC-SR04-style sensor: pulses `trig`, times the echo pulse in
//   microseconds and publishes the width on `measure` once per PERIOD_US
//   while `en` is high. The downstream display divides `measure` by 58.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   en       in   run enable, sampled only in IDLE
//   echo     in   raw (asynchronous) sensor echo, 2-FF synchronised here
//   trig     out  sensor trigger pulse (TRIG_US wide)
//   measure  out  last echo width in us, 16'hFFFF on timeout, held
//   valid    out  one-clock pulse whenever measure/timeout update
//   timeout  out  1 when the last cycle timed out, held with measure
// Build option:
//   MEDIAN3_EN  when defined, OK results pass through a 3-deep median window
//               (raw value until 3 are stored; timeouts bypass the window).
//               Adds one clock of valid latency.
// ----------------------------------------------------------------------------
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 27_000_000,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30_000,
    parameter int unsigned PERIOD_US  = 60_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] measure,
    output logic        valid,
    output logic        timeout
);

    localparam int unsigned TICKS = ticks_per_us(CLK_HZ);
    localparam int unsigned PRE_W = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam int unsigned PER_W = $clog2(PERIOD_US);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS - 1);
    // HOLD leaves two clocks before the period ends: one clock in IDLE, then
    // TRIG is entered exactly PERIOD_US*TICKS clocks after the previous entry.
    localparam logic [PRE_W-1:0] PRE_EXIT  = PRE_W'(TICKS - 2);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_US - 1);
    localparam logic [15:0]      TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT_US - 1);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;          // us in current state / echo width
    logic [PRE_W-1:0]   per_pre_q, per_pre_d;  // period prescaler, free-running from TRIG entry
    logic [PER_W-1:0]   per_us_q, per_us_d;    // us since TRIG entry
    logic [2:0]         echo_sync_q, echo_sync_d;
    logic               trig_q, trig_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic [15:0]        measure_q, measure_d;

    logic               tick;
    logic               tick_clr;
    logic               echo_rise;
    logic               echo_fall;

    us_tick #(
        .TICKS (TICKS)
    ) u_us_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // [0],[1] are the synchroniser; [2] is the previous synced value for edges.
    assign echo_sync_d = {echo_sync_q[1:0], echo};
    assign echo_rise   =  echo_sync_q[1] & ~echo_sync_q[2];
    assign echo_fall   = ~echo_sync_q[1] &  echo_sync_q[2];

    // ------------------------------------------------------------------
    // FSM next state and per-state microsecond counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tick_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) state_d = TRIG;
            end
            TRIG: begin
                if (tick) begin
                    if (cnt_q == TRIG_LAST) state_d = WAIT_RISE;
                    else                    cnt_d   = cnt_q + 16'd1;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                end else if (tick) begin
                    if (cnt_q == TO_LAST) state_d = DONE_TO;
                    else                  cnt_d   = cnt_q + 16'd1;
                end
            end
            MEASURE: begin
                // The tick in the fall-detect clock still counts, so the
                // width handed to DONE_OK includes the final microsecond.
                if (tick && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
                if (echo_fall)                   state_d = DONE_OK;
                else if (tick && (cnt_q == TO_LAST)) state_d = DONE_TO;
            end
            DONE_OK, DONE_TO: begin
                state_d = HOLD;
            end
            HOLD: begin
                if ((per_us_q == PER_LAST) && (per_pre_q == PRE_EXIT)) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tick_clr = 1'b1;
            if ((state_d == TRIG) || (state_d == WAIT_RISE) || (state_d == MEASURE)) begin
                cnt_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Period timer: restarts on TRIG entry, independent of state changes
    // ------------------------------------------------------------------
    always_comb begin
        per_pre_d = per_pre_q + PRE_W'(1);
        per_us_d  = per_us_q;
        if (per_pre_q == PRE_LAST) begin
            per_pre_d = '0;
            if (per_us_q != PER_LAST) per_us_d = per_us_q + PER_W'(1);
        end
        if ((state_d == TRIG) && (state_q != TRIG)) begin
            per_pre_d = '0;
            per_us_d  = '0;
        end
    end

    assign trig_d = (state_d == TRIG);

    // ------------------------------------------------------------------
    // Result publication
    // ------------------------------------------------------------------
`ifdef MEDIAN3_EN
    logic        pend_q, pend_d;        // result waiting one clock for the median
    logic        pend_to_q, pend_to_d;
    logic [15:0] win_q [3];             // [0] newest OK result
    logic [15:0] win_d [3];
    logic [1:0]  win_n_q, win_n_d;      // number of stored OK results, saturates at 3

    function automatic logic [15:0] median3(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [15:0] c);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      return lo;
        else if (c > hi) return hi;
        else             return c;
    endfunction
`endif

    always_comb begin
        valid_d   = 1'b0;
        measure_d = measure_q;
        timeout_d = timeout_q;
`ifdef MEDIAN3_EN
        pend_d    = (state_q == DONE_OK) || (state_q == DONE_TO);
        pend_to_d = (state_q == DONE_TO);
        win_n_d   = win_n_q;
        for (int i = 0; i < 3; i++) win_d[i] = win_q[i];

        if (state_q == DONE_OK) begin
            win_d[0] = cnt_q;
            win_d[1] = win_q[0];
            win_d[2] = win_q[1];
            if (win_n_q != 2'd3) win_n_d = win_n_q + 2'd1;
        end

        if (pend_q) begin
            valid_d = 1'b1;
            if (pend_to_q) begin
                measure_d = MEAS_TIMEOUT;
                timeout_d = 1'b1;
            end else begin
                timeout_d = 1'b0;
                measure_d = (win_n_q == 2'd3) ? median3(win_q[0], win_q[1], win_q[2])
                                              : win_q[0];
            end
        end
`else
        if (state_q == DONE_OK) begin
            valid_d   = 1'b1;
            measure_d = cnt_q;
            timeout_d = 1'b0;
        end else if (state_q == DONE_TO) begin
            valid_d   = 1'b1;
            measure_d = MEAS_TIMEOUT;
            timeout_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            per_pre_q   <= '0;
            per_us_q    <= '0;
            echo_sync_q <= '0;
            trig_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            measure_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_pre_q   <= per_pre_d;
            per_us_q    <= per_us_d;
            echo_sync_q <= echo_sync_d;
            trig_q      <= trig_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            measure_q   <= measure_d;
        end
    end

`ifdef MEDIAN3_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_to_q <= 1'b0;
            win_n_q   <= '0;
            for (int i = 0; i < 3; i++) win_q[i] <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_to_q <= pend_to_d;
            win_n_q   <= win_n_d;
            for (int i = 0; i < 3; i++) win_q[i] <= win_d[i];
        end
    end
`endif

    assign trig    = trig_q;
    assign measure = measure_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// ----------------------------------------------------------------------------
// tb_ultrasonic_ranger
//   Directed and randomised cycles against a behavioural model of the ranger.
//   Timing is scaled (3 MHz clock, 700 us timeout, 1450 us period) so the
//   whole run stays short; echo widths are scaled by 1/10 accordingly.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

    localparam int CLK_HZ     = 3_000_000;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 700;
    localparam int PERIOD_US  = 1450;
    localparam int T          = CLK_HZ / 1_000_000;
    localparam int PER_CLK    = PERIOD_US * T;
`ifdef MEDIAN3_EN
    localparam int LAT_OK     = 5;
    localparam bit MED        = 1'b1;
`else
    localparam int LAT_OK     = 4;
    localparam bit MED        = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        echo = 1'b0;
    logic        trig;
    logic        valid;
    logic        timeout;
    logic [15:0] measure;

    ultrasonic_ranger #(
        .CLK_HZ     (CLK_HZ),
        .TRIG_US    (TRIG_US),
        .TIMEOUT_US (TIMEOUT_US),
        .PERIOD_US  (PERIOD_US)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .echo    (echo),
        .trig    (trig),
        .measure (measure),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int          tests      = 0;
    int          fails      = 0;
    int          cyc        = 0;
    int          vcount     = 0;
    int          v_cyc      = 0;
    logic [15:0] v_meas     = '0;
    logic        v_to       = 1'b0;
    int          rise_cnt   = 0;
    int          last_rise  = -1;
    int          prev_rise  = -1;
    logic        trig_prev  = 1'b0;
    int          ok_hist[$];   // model of OK results since last reset

    // One clock; all observation happens at the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (valid === 1'b1) begin
            vcount++;
            v_cyc  = cyc;
            v_meas = measure;
            v_to   = timeout;
        end
        if (trig === 1'b1 && trig_prev !== 1'b1) begin
            rise_cnt++;
            prev_rise = last_rise;
            last_rise = cyc;
        end
        trig_prev = trig;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic int med3(input int a, input int b, input int c);
        int v[3];
        int t;
        v[0] = a; v[1] = b; v[2] = c;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return v[1];
    endfunction

    // One measurement cycle. width_us = 0 means the echo pin is left alone.
    task automatic do_cycle(input string tag, input int delay_us, input int width_us,
                            input bit expect_next);
        int n;
        int v0;
        int hi;
        int tfall;
        int efall;
        int e;
        bit no_rise;
        v0 = vcount;

        n = 0;
        while (trig !== 1'b1 && n < PER_CLK + 100) begin step(); n++; end
        chk({tag, ".trig_rise"}, 32'(trig), 32'd1);
        hi = 0;
        while (trig === 1'b1 && hi < TRIG_US * T + 20) begin step(); hi++; end
        chk({tag, ".trig_clks"}, 32'(hi), 32'(TRIG_US * T));
        tfall = cyc;

        no_rise = (width_us <= 0) || (delay_us >= TIMEOUT_US);
        if (width_us > 0) begin
            repeat (delay_us * T) step();
            echo = 1'b1;
            repeat (width_us * T) step();
            echo = 1'b0;
        end
        efall = cyc;

        n = 0;
        while (vcount == v0 && n < PER_CLK) begin step(); n++; end
        chk({tag, ".valid_seen"}, 32'(vcount > v0), 32'd1);

        if (no_rise || width_us > TIMEOUT_US) begin
            chk({tag, ".measure"}, 32'(v_meas), 32'hFFFF);
            chk({tag, ".timeout"}, 32'(v_to), 32'd1);
            if (no_rise)
                chk_range({tag, ".to_time"}, 32'(v_cyc - tfall),
                          32'(TIMEOUT_US * T), 32'(TIMEOUT_US * T + T + 2));
        end else begin
            ok_hist.push_back(width_us);
            if (MED && ok_hist.size() >= 3)
                e = med3(ok_hist[$], ok_hist[$-1], ok_hist[$-2]);
            else
                e = width_us;
            chk_range({tag, ".measure"}, 32'(v_meas), 32'(e - 1), 32'(e));
            chk({tag, ".timeout"}, 32'(v_to), 32'd0);
            chk({tag, ".latency"}, 32'(v_cyc - efall), 32'(LAT_OK));
        end

        if (expect_next) begin
            n = 0;
            while (trig !== 1'b1 && n < PER_CLK + 100) begin step(); n++; end
            chk({tag, ".period"}, 32'(last_rise - prev_rise), 32'(PER_CLK));
        end else begin
            repeat (10) step();
        end
        chk({tag, ".one_valid"}, 32'(vcount - v0), 32'd1);
        $display("[TB] %s: delay=%0d width=%0d measure=%0d timeout=%0d", tag,
                 delay_us, width_us, v_meas, v_to);
    endtask

    initial begin
        int r0;
        int w;
        int d;

        // 1: reset, then idle with en=0 for 1 ms
        rst = 1'b1; en = 1'b0; echo = 1'b0;
        repeat (5) step();
        chk("rst.trig", 32'(trig), 32'd0);
        chk("rst.measure", 32'(measure), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        r0 = rise_cnt;
        repeat (1000 * T) step();
        chk("idle.trig_rises", 32'(rise_cnt - r0), 32'd0);
        chk("idle.valids", 32'(vcount), 32'd0);
        $display("[TB] idle 1 ms: trig rises=%0d valids=%0d", rise_cnt - r0, vcount);

        // 2/3/6: OK widths, a no-echo timeout, then another OK width
        en = 1'b1;
        do_cycle("w58", 1, 58, 1'b1);
        do_cycle("w580", 1, 580, 1'b1);
        do_cycle("w60", 1, 60, 1'b1);
        do_cycle("norise", 0, 0, 1'b1);
        do_cycle("w59", 1, 59, 1'b1);

        // 4: echo stuck high from reset
        rst = 1'b1; echo = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        ok_hist.delete();
        do_cycle("stuck_a", 0, 0, 1'b1);
        do_cycle("stuck_b", 0, 0, 1'b1);
        echo = 1'b0;

        // 5: reset pulse in the middle of MEASURE
        r0 = 0;
        while (trig === 1'b1 && r0 < TRIG_US * T + 20) begin step(); r0++; end
        repeat (T) step();
        echo = 1'b1;
        repeat (50 * T) step();
        rst = 1'b1;
        step();
        chk("midrst.trig", 32'(trig), 32'd0);
        chk("midrst.valid", 32'(valid), 32'd0);
        chk("midrst.measure", 32'(measure), 32'd0);
        chk("midrst.timeout", 32'(timeout), 32'd0);
        $display("[TB] mid-measure reset: trig=%0d valid=%0d measure=%0d", trig, valid, measure);
        rst = 1'b0;
        echo = 1'b0;
        ok_hist.delete();
        do_cycle("restart", 2, 100, 1'b1);

        // echo longer than the timeout: width counter reaches TIMEOUT_US
        do_cycle("too_long", 3, TIMEOUT_US + 20, 1'b1);

        // randomised widths and delays
        for (int k = 0; k < 2; k++) begin
            w = int'($urandom_range(5, 650));
            d = int'($urandom_range(1, 40));
            do_cycle("rand", d, w, 1'b1);
        end

        // en dropped after the cycle started: cycle completes, then parks
        en = 1'b0;
        w = int'($urandom_range(5, 650));
        do_cycle("last", 4, w, 1'b0);
        r0 = rise_cnt;
        repeat (PER_CLK + 100) step();
        chk("park.trig_rises", 32'(rise_cnt - r0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: observed time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
